// File: rtl/bayes_posterior_engine.sv
// Accumulates per-class posteriors (stochastic popcount or log-sum), then sequential argmax.
// Latency: last beat accepted in cycle c -> out_valid high in cycle c+1+NCLASS.
// Backpressure: in_ready only in ACCUM; result held in DONE until out_ready.
module bayes_posterior_engine #(
  parameter int NCLASS     = 4,
  parameter int LW         = 8,
  parameter int NOBS       = 8,
  parameter int STREAM_LEN = 255,
  parameter int IW         = $clog2(NCLASS),
  parameter int AW         = ((LW + $clog2(NOBS + 1)) > $clog2(STREAM_LEN + 1)) ?
                             (LW + $clog2(NOBS + 1)) : $clog2(STREAM_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 abort,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCLASS-1:0]    in_bits,
  input  logic [NCLASS*LW-1:0] in_logs,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IW-1:0]        out_class,
  output logic [AW-1:0]        out_score
);

  typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, DONE} state_t;

  state_t          state;
  logic            mode_r;
  logic [AW-1:0]   acc [NCLASS];
  logic [AW-1:0]   count;
  logic [IW-1:0]   idx;
  logic [AW-1:0]   best;
  logic [IW-1:0]   best_idx;

  logic [AW-1:0]   target;
  logic [AW-1:0]   count_nxt;
  logic [AW-1:0]   cand;
  logic            take;

  // Beat target depends on the mode latched at start
  assign target    = mode_r ? AW'(NOBS) : AW'(STREAM_LEN);
  assign count_nxt = count + 1'b1;

  // Argmax step: class 0 seeds the running best; later classes must strictly win so ties keep the lower index
  always_comb begin
    cand = acc[idx];
    take = 1'b0;
    if (idx == '0)
      take = 1'b1;
    else if (mode_r)
      take = (cand < best);
    else
      take = (cand > best);
  end

  // Control FSM with accumulators and registered outputs; abort overrides everything outside IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_r    <= 1'b0;
      count     <= '0;
      idx       <= '0;
      best      <= '0;
      best_idx  <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_class <= '0;
      out_score <= '0;
      for (int k = 0; k < NCLASS; k++) acc[k] <= '0;
    end else if (abort && (state != IDLE)) begin
      state     <= IDLE;
      count     <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      for (int k = 0; k < NCLASS; k++) acc[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_r   <= mode;
            count    <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            state    <= ACCUM;
            for (int k = 0; k < NCLASS; k++) acc[k] <= '0;
          end
        end
        ACCUM: begin
          if (in_valid && in_ready) begin
            for (int k = 0; k < NCLASS; k++) begin
              if (mode_r)
                acc[k] <= acc[k] + AW'(in_logs[k*LW +: LW]);
              else
                acc[k] <= acc[k] + AW'(in_bits[k]);
            end
            count <= count_nxt;
            if (count_nxt == target) begin
              in_ready <= 1'b0;
              idx      <= '0;
              state    <= ARGMAX;
            end
          end
        end
        ARGMAX: begin
          if (take) begin
            best     <= cand;
            best_idx <= idx;
          end
          if (idx == IW'(NCLASS - 1)) begin
            out_class <= take ? idx : best_idx;
            out_score <= take ? cand : best;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bayes_posterior_engine.sv
// Randomized and directed bench for bayes_posterior_engine against a behavioural model.
// Latency: checks out_valid rise at last-beat cycle + 1 + NCLASS.
// Backpressure: random input gaps, held out_ready, handshake with concurrent start.
module tb_bayes_posterior_engine;
  localparam int NCLASS = 4;
  localparam int LW = 8;
  localparam int NOBS = 8;
  localparam int STREAM_LEN = 255;
  localparam int IW = 2;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic abort = 1'b0;
  logic busy;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [NCLASS-1:0] in_bits = '0;
  logic [NCLASS*LW-1:0] in_logs = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [IW-1:0] out_class;
  logic [AW-1:0] out_score;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_acc [NCLASS];

  bayes_posterior_engine #(
    .NCLASS(NCLASS), .LW(LW), .NOBS(NOBS), .STREAM_LEN(STREAM_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits), .in_logs(in_logs),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_score(out_score)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // all tasks start and end just after a negedge
  task automatic do_start(input logic m);
    for (int k = 0; k < NCLASS; k++) exp_acc[k] = 0;
    start = 1'b1;
    mode = m;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_busy", busy, 1);
    check_eq("start_in_ready", in_ready, 1);
  endtask

  // pat 0: random, 1: fixed pattern, 2: all-equal
  task automatic feed(input logic m, input int n, input int pat, input int gap, output int last_c);
    int sent;
    int guard;
    logic vld;
    logic [NCLASS-1:0] b;
    logic [NCLASS*LW-1:0] l;
    sent = 0;
    guard = 0;
    last_c = 0;
    while (sent < n && guard < 4000) begin
      vld = ($urandom_range(0, 99) >= gap);
      b = '0;
      l = '0;
      case (pat)
        0: begin
          b = NCLASS'($urandom);
          for (int k = 0; k < NCLASS; k++) l[k*LW +: LW] = LW'($urandom_range(0, 255));
        end
        1: begin
          b[1] = 1'b1;
          l = {8'd3, 8'd1, 8'd2, 8'd5};
        end
        default: begin
          for (int k = 0; k < NCLASS; k++) l[k*LW +: LW] = LW'(2);
        end
      endcase
      in_valid = vld;
      in_bits = b;
      in_logs = l;
      if (vld && in_ready) begin
        for (int k = 0; k < NCLASS; k++)
          exp_acc[k] += m ? int'(l[k*LW +: LW]) : int'(b[k]);
        sent++;
        last_c = cyc;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    check_eq("beats_sent", sent, n);
    if (n == (m ? NOBS : STREAM_LEN)) check_eq("in_ready_drop", in_ready, 0);
  endtask

  task automatic finish_check(input logic m, input int last_c, input int hold, input logic hs_start,
                              input int dir_cls, input int dir_sc);
    int g;
    int win;
    g = 0;
    win = 0;
    for (int k = 1; k < NCLASS; k++)
      if (m ? (exp_acc[k] < exp_acc[win]) : (exp_acc[k] > exp_acc[win])) win = k;
    while (!out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_eq("out_valid_rise", out_valid, 1);
    check_eq("latency", cyc - last_c, 1 + NCLASS);
    check_eq("out_class", out_class, win);
    check_eq("out_score", out_score, exp_acc[win]);
    if (dir_cls >= 0) check_eq("dir_class", out_class, dir_cls);
    if (dir_sc >= 0) check_eq("dir_score", out_score, dir_sc);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_busy", busy, 1);
      check_eq("hold_class", out_class, win);
      check_eq("hold_score", out_score, exp_acc[win]);
    end
    out_ready = 1'b1;
    start = hs_start;
    mode = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    check_eq("hs_valid_low", out_valid, 0);
    check_eq("hs_idle", busy, 0);
    check_eq("idle_keep_class", out_class, win);
    check_eq("idle_keep_score", out_score, exp_acc[win]);
  endtask

  initial begin
    int lc;
    logic m;
    // reset values
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_class", out_class, 0);
    check_eq("rst_score", out_score, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // async reset in the middle of accumulation
    do_start(1'b0);
    feed(1'b0, 20, 0, 0, lc);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_in_ready", in_ready, 0);
    check_eq("arst_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // log fixed pattern: accs {40,16,8,24}
    do_start(1'b1);
    feed(1'b1, NOBS, 1, 0, lc);
    finish_check(1'b1, lc, 0, 1'b0, 2, 8);

    // stochastic, class 1 always set; contiguous then 50% gaps
    do_start(1'b0);
    feed(1'b0, STREAM_LEN, 1, 0, lc);
    finish_check(1'b0, lc, 0, 1'b0, 1, 255);
    do_start(1'b0);
    feed(1'b0, STREAM_LEN, 1, 50, lc);
    finish_check(1'b0, lc, 2, 1'b0, 1, 255);

    // ties
    do_start(1'b1);
    feed(1'b1, NOBS, 2, 20, lc);
    finish_check(1'b1, lc, 0, 1'b0, 0, 16);
    do_start(1'b0);
    feed(1'b0, STREAM_LEN, 2, 0, lc);
    finish_check(1'b0, lc, 0, 1'b0, 0, 0);

    // long hold, then handshake with start in the same cycle
    do_start(1'b1);
    feed(1'b1, NOBS, 0, 30, lc);
    finish_check(1'b1, lc, 10, 1'b1, -1, -1);

    // abort after 3 beats, restart, start while busy must be ignored
    do_start(1'b1);
    feed(1'b1, 3, 0, 0, lc);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_in_ready", in_ready, 0);
    check_eq("abort_out_valid", out_valid, 0);
    do_start(1'b1);
    start = 1'b1;
    mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    mode = 1'b1;
    check_eq("busy_start_ignored", busy, 1);
    feed(1'b1, NOBS, 0, 0, lc);
    finish_check(1'b1, lc, 1, 1'b0, -1, -1);

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      m = 1'($urandom_range(0, 1));
      do_start(m);
      feed(m, m ? NOBS : STREAM_LEN, 0, $urandom_range(0, 60), lc);
      finish_check(m, lc, $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
